// File: rtl/usb_pkt_rx.sv
// USB 1.1 receive-side packet decoder: PID check, token/data/handshake split,
// CRC5/CRC16 residual checks and per-packet status flags from the UTMI byte stream.
module usb_pkt_rx #(
    parameter int MAX_PAYLOAD = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_error,
    output logic [3:0]  pid,
    output logic        pid_valid,
    output logic [6:0]  token_addr,
    output logic [3:0]  token_ep,
    output logic [10:0] frame_num,
    output logic        token_valid,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        data_done,
    output logic        crc5_err,
    output logic        crc16_err,
    output logic        pid_err,
    output logic        len_err,
    output logic        pkt_err
);
    localparam logic [2:0] IDLE = 3'd0, PID = 3'd1, TOK = 3'd2,
                           DATA = 3'd3, HSK = 3'd4, DROP = 3'd5;
    localparam int CNT_W = $clog2(MAX_PAYLOAD + 4) + 1;
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] FWD_MAX = CNT_W'(MAX_PAYLOAD + 1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [3:0]  PID_SOF    = 4'b0101;
    localparam logic [4:0]  CRC5_GOOD  = 5'b01100;
    localparam logic [15:0] CRC16_GOOD = 16'h800D;

    logic [2:0]       state;
    logic             activePrev;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       tokB1;
    logic [2:0]       tokB2Lo;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic [7:0]       hold0, hold1;
    logic             dropData;

    function automatic logic [4:0] crc5Byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
        return r;
    endfunction

    function automatic logic [15:0] crc16Byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    // A rising rx_active in IDLE may already carry the PID byte, so IDLE and PID share the check.
    logic start, pidPhase, pidOk;
    assign start    = (state == IDLE) && rx_active && !activePrev;
    assign pidPhase = (state == PID) || start;
    assign pidOk    = (rx_data[7:4] == ~rx_data[3:0]) && (rx_data[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            activePrev  <= 1'b1;
            cnt         <= '0;
            tokB1       <= '0;
            tokB2Lo     <= '0;
            crc5        <= '1;
            crc16       <= '1;
            hold0       <= '0;
            hold1       <= '0;
            dropData    <= 1'b0;
            pid         <= '0;
            pid_valid   <= 1'b0;
            token_addr  <= '0;
            token_ep    <= '0;
            frame_num   <= '0;
            token_valid <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_done   <= 1'b0;
            crc5_err    <= 1'b0;
            crc16_err   <= 1'b0;
            pid_err     <= 1'b0;
            len_err     <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            activePrev  <= rx_active;
            pid_valid   <= 1'b0;
            token_valid <= 1'b0;
            data_valid  <= 1'b0;
            data_done   <= 1'b0;
            if (pidPhase) begin
                if (!rx_active) begin
                    len_err <= 1'b1;
                    state   <= IDLE;
                end else if (rx_error) begin
                    pkt_err  <= 1'b1;
                    dropData <= 1'b0;
                    state    <= DROP;
                end else if (rx_valid) begin
                    crc5_err  <= 1'b0;
                    crc16_err <= 1'b0;
                    len_err   <= 1'b0;
                    pkt_err   <= 1'b0;
                    pid_err   <= !pidOk;
                    cnt       <= '0;
                    crc5      <= '1;
                    crc16     <= '1;
                    dropData  <= 1'b0;
                    if (!pidOk) begin
                        state <= DROP;
                    end else begin
                        pid       <= rx_data[3:0];
                        pid_valid <= 1'b1;
                        case (rx_data[1:0])
                            2'b01:   state <= TOK;
                            2'b11:   state <= DATA;
                            default: state <= HSK;
                        endcase
                    end
                end else begin
                    state <= PID;
                end
            end else if (state != IDLE) begin
                if (!rx_active) begin
                    case (state)
                        TOK: begin
                            if (cnt != CNT_TWO)    len_err  <= 1'b1;
                            if (crc5 != CRC5_GOOD) crc5_err <= 1'b1;
                            if (cnt == CNT_TWO && crc5 == CRC5_GOOD) begin
                                token_valid <= 1'b1;
                                token_addr  <= tokB1[6:0];
                                token_ep    <= {tokB2Lo, tokB1[7]};
                                if (pid == PID_SOF) frame_num <= {tokB2Lo, tokB1};
                            end
                        end
                        DATA: begin
                            data_done <= 1'b1;
                            if (cnt < CNT_TWO || crc16 != CRC16_GOOD) crc16_err <= 1'b1;
                            if (cnt > LEN_MAX) len_err <= 1'b1;
                        end
                        DROP:    if (dropData) data_done <= 1'b1;
                        default: ;
                    endcase
                    dropData <= 1'b0;
                    state    <= IDLE;
                end else if (rx_error) begin
                    pkt_err <= 1'b1;
                    if (state == DATA) dropData <= 1'b1;
                    state <= DROP;
                end else if (rx_valid) begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    case (state)
                        TOK: begin
                            if (cnt == '0) tokB1 <= rx_data;
                            if (cnt == CNT_W'(1)) tokB2Lo <= rx_data[2:0];
                            if (cnt < CNT_TWO) crc5 <= crc5Byte(crc5, rx_data);
                        end
                        DATA: begin
                            // Two bytes stay held back so the trailing CRC never reaches data_out.
                            crc16 <= crc16Byte(crc16, rx_data);
                            hold0 <= rx_data;
                            hold1 <= hold0;
                            if (cnt >= CNT_TWO && cnt <= FWD_MAX) begin
                                data_out   <= hold1;
                                data_valid <= 1'b1;
                            end
                        end
                        HSK:     len_err <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_pkt_rx.sv
// Directed bench for usb_pkt_rx: a packet-level model predicts pulses and flags, a monitor compares them.
module tb_usb_pkt_rx;
    typedef logic [7:0] u8;
    typedef u8 bq_t[$];
    localparam int MAXP = 1023;

    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0, rx_active = 1'b0, rx_error = 1'b0;
    logic [3:0] pid;
    logic pid_valid, token_valid, data_valid, data_done;
    logic [6:0] token_addr;
    logic [3:0] token_ep;
    logic [10:0] frame_num;
    logic [7:0] data_out;
    logic crc5_err, crc16_err, pid_err, len_err, pkt_err;

    usb_pkt_rx #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_error(rx_error), .pid(pid), .pid_valid(pid_valid),
        .token_addr(token_addr), .token_ep(token_ep), .frame_num(frame_num),
        .token_valid(token_valid), .data_out(data_out), .data_valid(data_valid),
        .data_done(data_done), .crc5_err(crc5_err), .crc16_err(crc16_err),
        .pid_err(pid_err), .len_err(len_err), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    int nCmp = 0, nBad = 0;
    logic [3:0]  expPid[$];
    u8           expData[$];
    logic [10:0] expTok[$];
    logic [4:0]  expDone[$];
    logic [4:0]  mFlags = '0;   // {crc5, crc16, pid, len, pkt}
    logic [3:0]  mPid = '0;
    logic [10:0] mTok = '0;     // {ep, addr}
    logic [10:0] mFrame = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CRC5 field as it appears in byte2[7:3] for an 11-bit token payload.
    function automatic logic [4:0] crc5Field(input logic [10:0] v);
        logic [4:0] c, f;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((v[i] ^ c[4]) ? 5'h05 : 5'h00);
        for (int k = 0; k < 5; k++) f[k] = ~c[4-k];
        return f;
    endfunction

    // CRC16 as {second byte, first byte} sent after the payload.
    function automatic logic [15:0] crc16Gen(input bq_t q);
        logic [15:0] c, f;
        c = 16'hFFFF;
        foreach (q[j])
            for (int i = 0; i < 8; i++)
                c = {c[14:0], 1'b0} ^ ((q[j][i] ^ c[15]) ? 16'h8005 : 16'h0000);
        for (int k = 0; k < 16; k++) f[k] = ~c[15-k];
        return f;
    endfunction

    task automatic modelPkt(input bq_t b, input int errAt);
        int L;
        u8 p;
        bq_t pl;
        bit crcBad, lenBad;
        if (b.size() == 0) begin
            mFlags[1] = 1'b1;
            return;
        end
        p = b[0];
        mFlags = '0;
        if (p[7:4] != ~p[3:0] || p[1:0] == 2'b00) begin
            mFlags[2] = 1'b1;
            return;
        end
        mPid = p[3:0];
        expPid.push_back(p[3:0]);
        L = (errAt > 0) ? errAt - 1 : b.size() - 1;
        if (errAt > 0) begin
            mFlags[0] = 1'b1;
            if (p[1:0] == 2'b11) begin
                for (int k = 0; k < L - 2; k++) expData.push_back(b[1+k]);
                expDone.push_back(mFlags);
            end
            return;
        end
        case (p[1:0])
            2'b01: begin
                lenBad = (L != 2);
                crcBad = 1'b1;
                if (L >= 2) crcBad = (crc5Field({b[2][2:0], b[1]}) != b[2][7:3]);
                mFlags[1] = lenBad;
                mFlags[4] = crcBad;
                if (!lenBad && !crcBad) begin
                    mTok = {b[2][2:0], b[1]};
                    expTok.push_back(mTok);
                    if (p[3:0] == 4'b0101) mFrame = {b[2][2:0], b[1]};
                end
            end
            2'b11: begin
                crcBad = 1'b1;
                if (L >= 2) begin
                    for (int k = 0; k < L - 2; k++) pl.push_back(b[1+k]);
                    crcBad = (crc16Gen(pl) != {b[L], b[L-1]});
                end
                for (int k = 0; k < L - 2 && k < MAXP; k++) expData.push_back(b[1+k]);
                mFlags[3] = crcBad;
                mFlags[1] = (L - 2 > MAXP);
                expDone.push_back(mFlags);
            end
            default: mFlags[1] = (L > 0);
        endcase
    endtask

    always @(negedge clk) if (rst) begin
        if (pid_valid) begin
            chk("pid_valid expected", 64'(expPid.size() > 0), 64'd1);
            if (expPid.size() > 0) chk("pid value", 64'(pid), 64'(expPid.pop_front()));
        end
        if (data_valid) begin
            chk("data_valid expected", 64'(expData.size() > 0), 64'd1);
            if (expData.size() > 0) chk("data_out", 64'(data_out), 64'(expData.pop_front()));
        end
        if (token_valid) begin
            chk("token_valid expected", 64'(expTok.size() > 0), 64'd1);
            if (expTok.size() > 0) chk("token fields", 64'({token_ep, token_addr}), 64'(expTok.pop_front()));
        end
        if (data_done) begin
            chk("data_done expected", 64'(expDone.size() > 0), 64'd1);
            if (expDone.size() > 0)
                chk("data_done flags", 64'({crc5_err, crc16_err, pid_err, len_err, pkt_err}),
                    64'(expDone.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveByte(input u8 d, input bit err);
        step();
        rx_data = d; rx_valid = 1'b1; rx_error = err;
        step();
        rx_valid = 1'b0; rx_error = 1'b0;
    endtask

    task automatic sendPkt(input bq_t b, input int errAt, input int gap);
        step();
        rx_active = 1'b1;
        foreach (b[i]) driveByte(b[i], i == errAt);
        step();
        rx_active = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic run(input bq_t b, input int errAt, input int gap);
        modelPkt(b, errAt);
        sendPkt(b, errAt, gap);
    endtask

    task automatic settle(input string tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, " missing pid_valid"}, 64'(expPid.size()), 64'd0);
        chk({tag, " missing data_valid"}, 64'(expData.size()), 64'd0);
        chk({tag, " missing token_valid"}, 64'(expTok.size()), 64'd0);
        chk({tag, " missing data_done"}, 64'(expDone.size()), 64'd0);
        chk({tag, " status"}, 64'({crc5_err, crc16_err, pid_err, len_err, pkt_err}), 64'(mFlags));
        chk({tag, " pid held"}, 64'(pid), 64'(mPid));
        chk({tag, " token held"}, 64'({token_ep, token_addr}), 64'(mTok));
        chk({tag, " frame_num"}, 64'(frame_num), 64'(mFrame));
        expPid.delete(); expData.delete(); expTok.delete(); expDone.delete();
    endtask

    function automatic logic [63:0] allOut();
        return 64'({pid, pid_valid, token_addr, token_ep, frame_num, token_valid, data_out,
                    data_valid, data_done, crc5_err, crc16_err, pid_err, len_err, pkt_err});
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t pay, pkt, bad, big, q;
        logic [15:0] c16;
        logic [4:0] f5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("outputs in reset", allOut(), 64'd0);
        rst = 1'b1;
        repeat (2) step();

        chk("crc5 model pin", 64'(crc5Field(11'h000)), 64'h02);
        q = {};
        chk("crc16 model pin empty", 64'(crc16Gen(q)), 64'h0000);

        run('{8'h2D, 8'h00, 8'h10}, -1, 3);
        settle("setup");
        chk("setup pid literal", 64'(pid), 64'hD);
        chk("setup crc5_err literal", 64'(crc5_err), 64'd0);

        run('{8'h69, 8'h00, 8'h11}, -1, 3);
        settle("in corrupt");
        chk("in crc5_err literal", 64'(crc5_err), 64'd1);

        run('{8'h4B, 8'h00, 8'h00}, -1, 3);
        settle("zlp");
        chk("zlp pid literal", 64'(pid), 64'hB);

        pay = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        c16 = crc16Gen(pay);
        pkt = {8'hC3, pay, c16[7:0], c16[15:8]};
        run(pkt, -1, 3);
        settle("data0 clean");
        chk("data0 crc16_err literal", 64'(crc16_err), 64'd0);
        bad = pkt;
        bad[3] = bad[3] ^ 8'h04;
        run(bad, -1, 3);
        settle("data0 flipped");
        chk("data0 flipped crc16_err literal", 64'(crc16_err), 64'd1);

        run('{8'h2C, 8'h00, 8'h10}, -1, 3);
        settle("bad pid");
        chk("bad pid_err literal", 64'(pid_err), 64'd1);
        run('{8'hD2}, -1, 3);
        settle("ack");
        chk("ack pid literal", 64'(pid), 64'h2);
        chk("ack pid_err cleared", 64'(pid_err), 64'd0);

        run(pkt, 3, 3);
        settle("rx_error data");
        chk("rx_error pkt_err literal", 64'(pkt_err), 64'd1);

        q = {};
        run(q, -1, 3);
        settle("eop in pid");
        run('{8'hD2, 8'h00}, -1, 3);
        settle("hsk extra");
        run('{8'h2D, 8'h00, 8'h10, 8'h00}, -1, 3);
        settle("token long");

        f5 = crc5Field(11'h123);
        run('{8'hA5, 8'h23, {f5, 3'b001}}, -1, 3);
        settle("sof");
        chk("sof frame literal", 64'(frame_num), 64'h123);

        run('{8'hD2}, -1, 1);
        run('{8'h69, 8'h15, 8'h10}, -1, 3);
        settle("back to back");

        big = {};
        for (int i = 0; i < MAXP + 1; i++) big.push_back(u8'(i * 7));
        c16 = crc16Gen(big);
        big = {8'h4B, big, c16[7:0], c16[15:8]};
        run(big, -1, 3);
        settle("overflow");
        chk("overflow len_err literal", 64'(len_err), 64'd1);

        // reset in the middle of a data packet
        expPid.push_back(4'h3);
        step();
        rx_active = 1'b1;
        driveByte(8'hC3, 1'b0);
        driveByte(8'h80, 1'b0);
        driveByte(8'h06, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("outputs in mid-packet reset", allOut(), 64'd0);
        mFlags = '0; mPid = '0; mTok = '0; mFrame = '0;
        repeat (2) step();
        rst = 1'b1;
        driveByte(8'h00, 1'b0);
        driveByte(8'hD2, 1'b0);
        step();
        rx_active = 1'b0;
        settle("after reset");
        run('{8'h2D, 8'h05, 8'h10}, -1, 3);
        settle("post reset setup");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
